// File: rtl/sram_rw_ctrl_if.sv
// Purpose : requester and SRAM-side signal bundle for sram_rw_ctrl.
// Latency : none, wires only.
// Backpressure: wr_ready / rd_ready are the only stall signals carried here.
// Ports   : write requester (wr_*), read requester (rd_*), busy,
//           SRAM port 0 write (sram_csb0/addr0/din0), SRAM port 1 byte read (sram_csb1/addr1/dout1).
//           slave modport = controller, master modport = requesters plus SRAM model.
interface sram_rw_ctrl_if;
   logic        wr_req;
   logic [10:0] wr_addr;
   logic [31:0] wr_data;
   logic        wr_ready;
   logic        rd_req;
   logic [10:0] rd_addr;
   logic        rd_ready;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        busy;
   logic        sram_csb0;
   logic [10:0] sram_addr0;
   logic [31:0] sram_din0;
   logic        sram_csb1;
   logic [12:0] sram_addr1;
   logic [7:0]  sram_dout1;

   modport slave (
      input  wr_req, wr_addr, wr_data, rd_req, rd_addr, sram_dout1,
      output wr_ready, rd_ready, rd_data, rd_valid, busy,
             sram_csb0, sram_addr0, sram_din0, sram_csb1, sram_addr1
   );

   modport master (
      output wr_req, wr_addr, wr_data, rd_req, rd_addr, sram_dout1,
      input  wr_ready, rd_ready, rd_data, rd_valid, busy,
             sram_csb0, sram_addr0, sram_din0, sram_csb1, sram_addr1
   );
endinterface

// File: rtl/sram_rw_ctrl.sv
// Purpose : 32-bit word write / 4x byte read controller for a dual-port SRAM (32b write, 8b read).
// Latency : write registered at the accept edge; read data + rd_valid 5 cycles after read accept.
// Backpressure: rd_ready low outside IDLE or on a same-word write; wr_ready low on the word being read.
// Ports   : clk, reset (sync, active high), bus (sram_rw_ctrl_if.slave).
module sram_rw_ctrl (
   input logic           clk,
   input logic           reset,
   sram_rw_ctrl_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [10:0] rd_word_q, rd_word_d;
   logic        csb0_q, csb0_d;
   logic [10:0] addr0_q, addr0_d;
   logic [31:0] din0_q, din0_d;
   logic        csb1_q, csb1_d;
   logic [12:0] addr1_q, addr1_d;
   logic [23:0] asm_q, asm_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        rd_valid_q, rd_valid_d;
   logic        busy_q, busy_d;

   logic wr_ready_c, rd_ready_c, wr_acc, rd_acc;

   // A write may not land on the word currently being read out byte by byte.
   assign wr_ready_c = !reset && !((state_q != S_IDLE) && (bus.wr_addr == rd_word_q));
   assign wr_acc     = bus.wr_req && wr_ready_c;

   // A read waits for any write to its word, whether already registered toward
   // the SRAM or being accepted this cycle, so it always sees the new data.
   assign rd_ready_c = !reset && (state_q == S_IDLE)
                       && !(!csb0_q && (addr0_q == bus.rd_addr))
                       && !(wr_acc && (bus.wr_addr == bus.rd_addr));
   assign rd_acc     = bus.rd_req && rd_ready_c;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rd_word_d  = rd_word_q;
      csb0_d     = 1'b1;
      addr0_d    = addr0_q;
      din0_d     = din0_q;
      csb1_d     = csb1_q;
      addr1_d    = addr1_q;
      asm_d      = asm_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;

      if (wr_acc) begin
         csb0_d  = 1'b0;
         addr0_d = bus.wr_addr;
         din0_d  = bus.wr_data;
      end

      case (state_q)
         S_IDLE: begin
            if (rd_acc) begin
               state_d   = S_ISSUE;
               cnt_d     = 2'd0;
               rd_word_d = bus.rd_addr;
               csb1_d    = 1'b0;
               addr1_d   = {bus.rd_addr, 2'b00};
            end
         end
         S_ISSUE: begin
            // SRAM read takes one cycle, so the byte issued two edges ago
            // (lane cnt_q-1) is on sram_dout1 now.
            case (cnt_q)
               2'd1:    asm_d[7:0]   = bus.sram_dout1;
               2'd2:    asm_d[15:8]  = bus.sram_dout1;
               2'd3:    asm_d[23:16] = bus.sram_dout1;
               default: ;
            endcase
            if (cnt_q == 2'd3) begin
               state_d = S_DRAIN;
               csb1_d  = 1'b1;
            end else begin
               cnt_d   = cnt_q + 2'd1;
               addr1_d = {rd_word_q, cnt_q + 2'd1};
            end
         end
         S_DRAIN: begin
            // Last lane arrives now; rd_data updates only here so it holds
            // steady between rd_valid pulses.
            rd_data_d  = {bus.sram_dout1, asm_q};
            rd_valid_d = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE) || wr_acc;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= 2'd0;
         rd_word_q  <= 11'd0;
         csb0_q     <= 1'b1;
         addr0_q    <= 11'd0;
         din0_q     <= 32'd0;
         csb1_q     <= 1'b1;
         addr1_q    <= 13'd0;
         asm_q      <= 24'd0;
         rd_data_q  <= 32'd0;
         rd_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_word_q  <= rd_word_d;
         csb0_q     <= csb0_d;
         addr0_q    <= addr0_d;
         din0_q     <= din0_d;
         csb1_q     <= csb1_d;
         addr1_q    <= addr1_d;
         asm_q      <= asm_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.wr_ready   = wr_ready_c;
   assign bus.rd_ready   = rd_ready_c;
   assign bus.rd_data    = rd_data_q;
   assign bus.rd_valid   = rd_valid_q;
   assign bus.busy       = busy_q;
   assign bus.sram_csb0  = csb0_q;
   assign bus.sram_addr0 = addr0_q;
   assign bus.sram_din0  = din0_q;
   assign bus.sram_csb1  = csb1_q;
   assign bus.sram_addr1 = addr1_q;

endmodule

// File: tb/tb_sram_rw_ctrl.sv
// Purpose : self-checking bench for sram_rw_ctrl with a behavioural dual-port SRAM.
// Latency : SRAM model returns a read byte one cycle after sram_csb1/sram_addr1 are registered.
// Backpressure: requests are held until the DUT raises the matching ready.
module tb_sram_rw_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   sram_rw_ctrl_if bus ();

   sram_rw_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM: 32-bit write port, 8-bit read port, 1-cycle read latency.
   logic [7:0] mem [0:8191];
   always @(posedge clk) begin
      if (!bus.sram_csb0) begin
         mem[{bus.sram_addr0, 2'd0}] <= bus.sram_din0[7:0];
         mem[{bus.sram_addr0, 2'd1}] <= bus.sram_din0[15:8];
         mem[{bus.sram_addr0, 2'd2}] <= bus.sram_din0[23:16];
         mem[{bus.sram_addr0, 2'd3}] <= bus.sram_din0[31:24];
      end
      if (!bus.sram_csb1) bus.sram_dout1 <= mem[bus.sram_addr1];
   end

   typedef struct {
      logic        rst, wq;
      logic [10:0] wa;
      logic [31:0] wd;
      logic        rq;
      logic [10:0] ra;
      logic        e_wr, e_rd, e_csb0;
      logic [10:0] e_a0;
      logic [31:0] e_d0;
      logic        e_csb1;
      logic [12:0] e_a1;
      logic        e_vld;
      logic [31:0] e_dat;
      logic        e_busy;
   } vec_t;

   vec_t tbl [18];

   function automatic vec_t mk(logic [31:0] rst, logic [31:0] wq, logic [31:0] wa, logic [31:0] wd,
                               logic [31:0] rq, logic [31:0] ra, logic [31:0] e_wr, logic [31:0] e_rd,
                               logic [31:0] e_csb0, logic [31:0] e_a0, logic [31:0] e_d0,
                               logic [31:0] e_csb1, logic [31:0] e_a1, logic [31:0] e_vld,
                               logic [31:0] e_dat, logic [31:0] e_busy);
      vec_t v;
      v.rst = rst[0];     v.wq = wq[0];         v.wa = wa[10:0];     v.wd = wd;
      v.rq = rq[0];       v.ra = ra[10:0];      v.e_wr = e_wr[0];    v.e_rd = e_rd[0];
      v.e_csb0 = e_csb0[0]; v.e_a0 = e_a0[10:0]; v.e_d0 = e_d0;     v.e_csb1 = e_csb1[0];
      v.e_a1 = e_a1[12:0]; v.e_vld = e_vld[0];  v.e_dat = e_dat;     v.e_busy = e_busy[0];
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic wq, input logic [10:0] wa, input logic [31:0] wd,
                        input logic rq, input logic [10:0] ra);
      bus.wr_req = wq; bus.wr_addr = wa; bus.wr_data = wd;
      bus.rd_req = rq; bus.rd_addr = ra;
   endtask

   // Full read: wait (bounded) for rd_ready, accept, expect rd_valid exactly 5 edges later.
   task automatic do_read(input string name, input logic [10:0] a, input logic [31:0] exp);
      int n;
      int lat;
      drive(1'b0, 11'd0, 32'd0, 1'b1, a);
      #1;
      n = 0;
      while (!bus.rd_ready && n < 20) begin
         step();
         n++;
      end
      chk({name, " ready timeout"}, 32'(n < 20), 32'd1);
      step();
      bus.rd_req = 1'b0;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (bus.rd_valid) begin
            lat = i;
            break;
         end
      end
      chk({name, " latency"}, 32'(lat), 32'd5);
      chk({name, " data"}, bus.rd_data, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int   seen;
      logic [12:0] max_a1;

      //            rst wq wa     wd           rq ra     wr rd csb0 a0     d0           csb1 a1      vld dat          busy
      tbl[0]  = mk(1, 1, 'h005, 'h55555555, 1, 'h007, 0, 0, 1, 'h000, 'h00000000, 1, 'h0000, 0, 'h00000000, 0);
      tbl[1]  = mk(0, 1, 'h005, 'hA1B2C3D4, 0, 'h000, 1, 1, 0, 'h005, 'hA1B2C3D4, 1, 'h0000, 0, 'h00000000, 1);
      tbl[2]  = mk(0, 0, 'h005, 'hA1B2C3D4, 1, 'h005, 1, 0, 1, 'h005, 'hA1B2C3D4, 1, 'h0000, 0, 'h00000000, 0);
      tbl[3]  = mk(0, 0, 'h005, 'hA1B2C3D4, 1, 'h005, 1, 1, 1, 'h005, 'hA1B2C3D4, 0, 'h0014, 0, 'h00000000, 1);
      tbl[4]  = mk(0, 0, 'h005, 'hA1B2C3D4, 0, 'h005, 0, 0, 1, 'h005, 'hA1B2C3D4, 0, 'h0015, 0, 'h00000000, 1);
      tbl[5]  = mk(0, 0, 'h005, 'hA1B2C3D4, 0, 'h005, 0, 0, 1, 'h005, 'hA1B2C3D4, 0, 'h0016, 0, 'h00000000, 1);
      tbl[6]  = mk(0, 0, 'h005, 'hA1B2C3D4, 0, 'h005, 0, 0, 1, 'h005, 'hA1B2C3D4, 0, 'h0017, 0, 'h00000000, 1);
      tbl[7]  = mk(0, 0, 'h005, 'hA1B2C3D4, 0, 'h005, 0, 0, 1, 'h005, 'hA1B2C3D4, 1, 'h0017, 0, 'h00000000, 1);
      tbl[8]  = mk(0, 0, 'h005, 'hA1B2C3D4, 0, 'h005, 0, 0, 1, 'h005, 'hA1B2C3D4, 1, 'h0017, 1, 'hA1B2C3D4, 0);
      tbl[9]  = mk(0, 0, 'h005, 'hA1B2C3D4, 0, 'h005, 1, 1, 1, 'h005, 'hA1B2C3D4, 1, 'h0017, 0, 'hA1B2C3D4, 0);
      tbl[10] = mk(0, 1, 'h010, 'h11223344, 1, 'h010, 1, 0, 0, 'h010, 'h11223344, 1, 'h0017, 0, 'hA1B2C3D4, 1);
      tbl[11] = mk(0, 0, 'h010, 'h11223344, 1, 'h010, 1, 0, 1, 'h010, 'h11223344, 1, 'h0017, 0, 'hA1B2C3D4, 0);
      tbl[12] = mk(0, 0, 'h010, 'h11223344, 1, 'h010, 1, 1, 1, 'h010, 'h11223344, 0, 'h0040, 0, 'hA1B2C3D4, 1);
      tbl[13] = mk(0, 0, 'h010, 'h11223344, 0, 'h010, 0, 0, 1, 'h010, 'h11223344, 0, 'h0041, 0, 'hA1B2C3D4, 1);
      tbl[14] = mk(0, 0, 'h010, 'h11223344, 0, 'h010, 0, 0, 1, 'h010, 'h11223344, 0, 'h0042, 0, 'hA1B2C3D4, 1);
      tbl[15] = mk(0, 0, 'h010, 'h11223344, 0, 'h010, 0, 0, 1, 'h010, 'h11223344, 0, 'h0043, 0, 'hA1B2C3D4, 1);
      tbl[16] = mk(0, 0, 'h010, 'h11223344, 0, 'h010, 0, 0, 1, 'h010, 'h11223344, 1, 'h0043, 0, 'hA1B2C3D4, 1);
      tbl[17] = mk(0, 0, 'h010, 'h11223344, 0, 'h010, 0, 0, 1, 'h010, 'h11223344, 1, 'h0043, 1, 'h11223344, 0);

      drive(1'b0, 11'd0, 32'd0, 1'b0, 11'd0);
      reset = 1'b1;
      step();
      step();

      // Cycle-by-cycle vectors: readies checked before the edge, registers after it.
      for (int i = 0; i < 18; i++) begin
         reset = tbl[i].rst;
         drive(tbl[i].wq, tbl[i].wa, tbl[i].wd, tbl[i].rq, tbl[i].ra);
         #1;
         chk($sformatf("row%0d wr_ready", i), 32'(bus.wr_ready), 32'(tbl[i].e_wr));
         chk($sformatf("row%0d rd_ready", i), 32'(bus.rd_ready), 32'(tbl[i].e_rd));
         step();
         chk($sformatf("row%0d sram_csb0", i),  32'(bus.sram_csb0),  32'(tbl[i].e_csb0));
         chk($sformatf("row%0d sram_addr0", i), 32'(bus.sram_addr0), 32'(tbl[i].e_a0));
         chk($sformatf("row%0d sram_din0", i),  bus.sram_din0,       tbl[i].e_d0);
         chk($sformatf("row%0d sram_csb1", i),  32'(bus.sram_csb1),  32'(tbl[i].e_csb1));
         chk($sformatf("row%0d sram_addr1", i), 32'(bus.sram_addr1), 32'(tbl[i].e_a1));
         chk($sformatf("row%0d rd_valid", i),   32'(bus.rd_valid),   32'(tbl[i].e_vld));
         chk($sformatf("row%0d rd_data", i),    bus.rd_data,         tbl[i].e_dat);
         chk($sformatf("row%0d busy", i),       32'(bus.busy),       32'(tbl[i].e_busy));
      end

      // Top word: write 0xDEADBEEF to 0x7FF, then read it while probing write hazards.
      drive(1'b1, 11'h7FF, 32'hDEADBEEF, 1'b0, 11'd0);
      #1;
      chk("top wr_ready", 32'(bus.wr_ready), 32'd1);
      step();
      bus.wr_req = 1'b0;
      step();
      bus.rd_req = 1'b1;
      bus.rd_addr = 11'h7FF;
      #1;
      chk("top rd_ready", 32'(bus.rd_ready), 32'd1);
      step();
      bus.rd_req = 1'b0;
      chk("top csb1 at accept", 32'(bus.sram_csb1), 32'd0);
      chk("top addr1 at accept", 32'(bus.sram_addr1), 32'h1FFC);
      max_a1 = bus.sram_addr1;
      for (int k = 1; k <= 5; k++) begin
         if (k == 2) drive(1'b1, 11'h100, 32'h0BADF00D, 1'b0, 11'd0);
         else        drive(1'b1, 11'h7FF, 32'h00000000, 1'b0, 11'd0);
         #1;
         chk($sformatf("hazard wr_ready k%0d", k), 32'(bus.wr_ready), (k == 2) ? 32'd1 : 32'd0);
         step();
         if (bus.sram_addr1 > max_a1) max_a1 = bus.sram_addr1;
         if (k == 2) begin
            chk("other-word write csb0", 32'(bus.sram_csb0), 32'd0);
            chk("other-word write addr0", 32'(bus.sram_addr0), 32'h100);
         end
         if (k < 5) chk($sformatf("top rd_valid early k%0d", k), 32'(bus.rd_valid), 32'd0);
      end
      chk("top rd_valid", 32'(bus.rd_valid), 32'd1);
      chk("top rd_data", bus.rd_data, 32'hDEADBEEF);
      chk("top max addr1", 32'(max_a1), 32'h1FFF);
      bus.wr_addr = 11'h7FF;
      #1;
      chk("top wr_ready after idle", 32'(bus.wr_ready), 32'd1);
      bus.wr_req = 1'b0;
      step();

      // Four back-to-back writes.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 11'(i), 32'h10000000 + 32'(i), 1'b0, 11'd0);
         #1;
         chk($sformatf("b2b%0d wr_ready", i), 32'(bus.wr_ready), 32'd1);
         step();
         chk($sformatf("b2b%0d csb0", i),  32'(bus.sram_csb0),  32'd0);
         chk($sformatf("b2b%0d addr0", i), 32'(bus.sram_addr0), 32'(i));
         chk($sformatf("b2b%0d din0", i),  bus.sram_din0,       32'h10000000 + 32'(i));
         chk($sformatf("b2b%0d busy", i),  32'(bus.busy),       32'd1);
      end
      bus.wr_req = 1'b0;
      step();
      chk("b2b end csb0", 32'(bus.sram_csb0), 32'd1);
      chk("b2b end busy", 32'(bus.busy), 32'd0);

      // Reset at edge A+3 of a read of 0x005.
      drive(1'b0, 11'd0, 32'd0, 1'b1, 11'h005);
      #1;
      chk("abort rd_ready", 32'(bus.rd_ready), 32'd1);
      step();
      bus.rd_req = 1'b0;
      step();
      step();
      reset = 1'b1;
      drive(1'b1, 11'h200, 32'hCAFEF00D, 1'b1, 11'h201);
      #1;
      chk("reset wr_ready", 32'(bus.wr_ready), 32'd0);
      chk("reset rd_ready", 32'(bus.rd_ready), 32'd0);
      step();
      chk("reset csb0",     32'(bus.sram_csb0),  32'd1);
      chk("reset csb1",     32'(bus.sram_csb1),  32'd1);
      chk("reset addr0",    32'(bus.sram_addr0), 32'd0);
      chk("reset addr1",    32'(bus.sram_addr1), 32'd0);
      chk("reset din0",     bus.sram_din0,       32'd0);
      chk("reset rd_data",  bus.rd_data,         32'd0);
      chk("reset rd_valid", 32'(bus.rd_valid),   32'd0);
      chk("reset busy",     32'(bus.busy),       32'd0);
      reset = 1'b0;
      drive(1'b0, 11'd0, 32'd0, 1'b0, 11'd0);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (bus.rd_valid) seen++;
      end
      chk("abort no rd_valid", 32'(seen), 32'd0);
      chk("abort rd_data held", bus.rd_data, 32'd0);
      do_read("post-reset read", 11'h005, 32'hA1B2C3D4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
